mc_ctrl_fsm: RTL and testbench
==============================

// Module: mc_ctrl_fsm
// PURPOSE
//  Parametrised multi-cycle MIPS32 control FSM; drives the datapath's IR/MDR/A/B/PC write enables, muxes and ALU op.
//  Adds over the previous control FSM: J, R-type funct decode, a mem_ack wait handshake with timeout,
//  and a sticky TRAP state for illegal opcode/funct or memory timeout. Sits between the IR fields and the datapath.
// PARAMETERS
//  OP_W     6   opcode field width
//  FUNC_W   6   funct field width
//  ALUOP_W  4   alu_op width; codes ADD=2, SUB=6, AND=0, OR=1, SLT=7, zero-extended
//  TO_W     4   memory-wait counter width
//  TO_MAX   15  wait cycles without mem_ack before TRAP; 1..2^TO_W-1
// PORTS
//  clk         in   1        clock
//  nrst        in   1        async active-low reset
//  op          in   OP_W     IR[31:26]
//  func        in   FUNC_W   IR[5:0]
//  mem_ack     in   1        memory done this cycle (read data valid / write accepted)
//  trap_clr    in   1        leave TRAP, refetch
//  ir_wr, mdr_wr, rega_wr, regb_wr  out 1  register load enables
//  reg_wr, reg_dst, mem_to_reg      out 1  regfile write enable / dest rd(1) vs rt(0) / data MDR(1) vs ALUOut(0)
//  alu_src_a   out  1        0=PC, 1=A
//  alu_src_b   out  3        0=B, 1=const 4, 2=sign-ext imm, 3=sign-ext imm<<2
//  alu_op      out  ALUOP_W  ALU function
//  pc_src      out  2        0=ALU, 1=ALUOut, 2=jump target
//  pc_wr, pc_wr_cond         out 1  unconditional PC load / PC load if ALU zero
//  i_or_d, mem_rd, mem_wr    out 1  address PC(0) vs ALUOut(1); memory strobes
//  trap        out  1        high in TRAP
//  trap_cause  out  2        0=none, 1=illegal op, 2=illegal funct, 3=mem timeout; reg, sticky
//  state_o     out  4        current state, debug
// BEHAVIOUR
//  - Clock domain: single clk. nrst low: state=IF, wait_cnt=0, trap_cause=0; every output forced 0 combinationally.
//  - State register only; outputs combinational from state (Moore), except ack-qualified enables below.
//  - Encodings: IF0 ID1 EXE_R2 EXE_I3 EXE_BR4 EXE_MA5 MEM_LW6 MEM_SW7 WB_R8 WB_I9 WB_LW10 JMP11 TRAP12.
//    13-15 unreachable -> IF next cycle, outputs 0.
//  - Opcodes: R=0x00, J=0x02, BEQ=0x04, ADDI=0x08, LW=0x23, SW=0x2B; anything else illegal.
//  - IF: mem_rd=1, i_or_d=0, alu_src_a=0, alu_src_b=1, alu_op=ADD, pc_src=0.
//    Hold until mem_ack; ir_wr=pc_wr=mem_ack. mem_ack -> ID.
//  - ID: rega_wr=regb_wr=1, alu_src_a=0, alu_src_b=3, alu_op=ADD.
//    Next by op: R->EXE_R, ADDI->EXE_I, BEQ->EXE_BR, LW/SW->EXE_MA, J->JMP, else TRAP (cause 1).
//  - EXE_R: alu_src_a=1, alu_src_b=0; alu_op from func: 0x20 ADD, 0x22 SUB, 0x24 AND, 0x25 OR, 0x2A SLT.
//    Other func -> TRAP (cause 2), no write.
//  - EXE_I / EXE_MA: alu_src_a=1, alu_src_b=2, alu_op=ADD. EXE_I->WB_I; EXE_MA->MEM_LW (LW) or MEM_SW (SW).
//  - EXE_BR: alu_src_a=1, alu_src_b=0, alu_op=SUB, pc_src=1, pc_wr_cond=1 -> IF.
//  - JMP: pc_src=2, pc_wr=1 -> IF.
//  - MEM_LW: mem_rd=1, i_or_d=1, mdr_wr=mem_ack; ack -> WB_LW.  MEM_SW: mem_wr=1, i_or_d=1; ack -> IF.
//  - WB_R: reg_wr=1, reg_dst=1, mem_to_reg=0.  WB_I: reg_wr=1, reg_dst=0, mem_to_reg=0.
//    WB_LW: reg_wr=1, reg_dst=0, mem_to_reg=1. All -> IF.
//  - Wait counter: increments each cycle in IF/MEM_LW/MEM_SW without mem_ack; cleared on ack or state exit.
//    Counter==TO_MAX with no ack -> TRAP (cause 3) next edge; ack arriving that same cycle wins (normal path).
//    Counter saturates, never wraps.
//  - TRAP: all strobes 0, trap=1. trap_clr -> IF, cause cleared on that edge; else stay.
//  - Reset mid-operation: strobes drop immediately; memory transaction abandoned; refetch from IF after release.
//  - Latencies with ack in first cycle: R/ADDI 4, LW 5, SW 4, BEQ 3, J 3; each wait cycle adds 1.
// CONFIGURATION
//  MC_CTRL_BNE_EN defined: opcode 0x05 (BNE) decodes to EXE_BR; same outputs except pc_wr_cond loads PC when
//  ALU zero=0, signalled via extra output br_ne (1 in EXE_BR for BNE, else 0).
//  Undefined: 0x05 illegal (TRAP, cause 1); br_ne port absent.
// TESTING
//  - nrst low mid-MEM_LW -> all outputs 0 same cycle; release -> state_o=0, mem_rd=1.
//  - op=0x00 func=0x22, ack every IF -> states 0,1,2,8,0; alu_op=6 in EXE_R; reg_wr=1,reg_dst=1 in WB_R.
//  - op=0x23, ack delayed 3 cycles in MEM_LW -> mdr_wr pulses once on ack cycle; WB_LW mem_to_reg=1; total 8 cycles.
//  - op=0x3F -> ID then TRAP, trap_cause=1; trap_clr pulse -> IF, trap_cause=0.
//  - no mem_ack in IF, TO_MAX=15 -> TRAP after 16 IF cycles, cause=3; ack on 16th cycle -> ID instead.
//  - op=0x05: with MC_CTRL_BNE_EN -> EXE_BR, br_ne=1; without -> TRAP, cause 1.

Source files
------------

// File: rtl/mc_ctrl_fsm.sv
// Multi-cycle MIPS32 control FSM: Moore outputs from state plus ack-qualified loads, memory-wait timeout and sticky trap.
// Optional BNE support is compiled in with MC_CTRL_BNE_EN (adds the br_ne output).
module mc_ctrl_fsm #(
    parameter int OP_W    = 6,
    parameter int FUNC_W  = 6,
    parameter int ALUOP_W = 4,
    parameter int TO_W    = 4,
    parameter int TO_MAX  = 15
) (
    input  logic               clk,
    input  logic               nrst,
    input  logic [OP_W-1:0]    op,
    input  logic [FUNC_W-1:0]  func,
    input  logic               mem_ack,
    input  logic               trap_clr,
    output logic               ir_wr,
    output logic               mdr_wr,
    output logic               rega_wr,
    output logic               regb_wr,
    output logic               reg_wr,
    output logic               reg_dst,
    output logic               mem_to_reg,
    output logic               alu_src_a,
    output logic [2:0]         alu_src_b,
    output logic [ALUOP_W-1:0] alu_op,
    output logic [1:0]         pc_src,
    output logic               pc_wr,
    output logic               pc_wr_cond,
    output logic               i_or_d,
    output logic               mem_rd,
    output logic               mem_wr,
    output logic               trap,
    output logic [1:0]         trap_cause,
    output logic [3:0]         state_o
`ifdef MC_CTRL_BNE_EN
    ,
    output logic               br_ne
`endif
);

    typedef enum logic [3:0] {
        S_IF     = 4'd0,  S_ID     = 4'd1,  S_EXE_R  = 4'd2,  S_EXE_I = 4'd3,
        S_EXE_BR = 4'd4,  S_EXE_MA = 4'd5,  S_MEM_LW = 4'd6,  S_MEM_SW = 4'd7,
        S_WB_R   = 4'd8,  S_WB_I   = 4'd9,  S_WB_LW  = 4'd10, S_JMP   = 4'd11,
        S_TRAP   = 4'd12
    } state_t;

    localparam logic [OP_W-1:0] OP_R    = OP_W'(6'h00);
    localparam logic [OP_W-1:0] OP_J    = OP_W'(6'h02);
    localparam logic [OP_W-1:0] OP_BEQ  = OP_W'(6'h04);
    localparam logic [OP_W-1:0] OP_BNE  = OP_W'(6'h05);
    localparam logic [OP_W-1:0] OP_ADDI = OP_W'(6'h08);
    localparam logic [OP_W-1:0] OP_LW   = OP_W'(6'h23);
    localparam logic [OP_W-1:0] OP_SW   = OP_W'(6'h2B);

    localparam logic [FUNC_W-1:0] F_ADD = FUNC_W'(6'h20);
    localparam logic [FUNC_W-1:0] F_SUB = FUNC_W'(6'h22);
    localparam logic [FUNC_W-1:0] F_AND = FUNC_W'(6'h24);
    localparam logic [FUNC_W-1:0] F_OR  = FUNC_W'(6'h25);
    localparam logic [FUNC_W-1:0] F_SLT = FUNC_W'(6'h2A);

    localparam logic [ALUOP_W-1:0] ALU_AND = ALUOP_W'(4'd0);
    localparam logic [ALUOP_W-1:0] ALU_OR  = ALUOP_W'(4'd1);
    localparam logic [ALUOP_W-1:0] ALU_ADD = ALUOP_W'(4'd2);
    localparam logic [ALUOP_W-1:0] ALU_SUB = ALUOP_W'(4'd6);
    localparam logic [ALUOP_W-1:0] ALU_SLT = ALUOP_W'(4'd7);

    localparam logic [1:0] CAUSE_NONE = 2'd0;
    localparam logic [1:0] CAUSE_OP   = 2'd1;
    localparam logic [1:0] CAUSE_FUNC = 2'd2;
    localparam logic [1:0] CAUSE_TO   = 2'd3;

    localparam logic [TO_W-1:0] WAIT_LIMIT = TO_W'(TO_MAX);
    localparam logic [TO_W-1:0] WAIT_SAT   = {TO_W{1'b1}};

    state_t          state_r, next_s;
    logic [TO_W-1:0] wait_cnt_r, wait_nxt_s;
    logic [1:0]      cause_r, cause_nxt_s;
    logic            timeout_s;

    assign timeout_s = (wait_cnt_r == WAIT_LIMIT) && !mem_ack;

    // State, wait counter and trap cause registers.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_r    <= S_IF;
            wait_cnt_r <= {TO_W{1'b0}};
            cause_r    <= CAUSE_NONE;
        end else begin
            state_r    <= next_s;
            wait_cnt_r <= wait_nxt_s;
            cause_r    <= cause_nxt_s;
        end
    end

    // Next-state decode and Moore outputs; reset forces every output low immediately.
    always_comb begin
        next_s      = S_IF;
        cause_nxt_s = cause_r;
        ir_wr = 1'b0; mdr_wr = 1'b0; rega_wr = 1'b0; regb_wr = 1'b0;
        reg_wr = 1'b0; reg_dst = 1'b0; mem_to_reg = 1'b0;
        alu_src_a = 1'b0; alu_src_b = 3'd0; alu_op = ALU_AND; pc_src = 2'd0;
        pc_wr = 1'b0; pc_wr_cond = 1'b0; i_or_d = 1'b0; mem_rd = 1'b0; mem_wr = 1'b0;
        trap = 1'b0; trap_cause = 2'd0; state_o = 4'd0;
`ifdef MC_CTRL_BNE_EN
        br_ne = 1'b0;
`endif
        if (!nrst) begin
            next_s = S_IF;
        end else begin
            state_o    = state_r;
            trap_cause = cause_r;
            case (state_r)
                S_IF: begin
                    mem_rd = 1'b1; alu_src_b = 3'd1; alu_op = ALU_ADD;
                    ir_wr  = mem_ack; pc_wr = mem_ack;
                    if (mem_ack)        next_s = S_ID;
                    else if (timeout_s) begin next_s = S_TRAP; cause_nxt_s = CAUSE_TO; end
                    else                next_s = S_IF;
                end
                S_ID: begin
                    rega_wr = 1'b1; regb_wr = 1'b1; alu_src_b = 3'd3; alu_op = ALU_ADD;
                    case (op)
                        OP_R:         next_s = S_EXE_R;
                        OP_ADDI:      next_s = S_EXE_I;
                        OP_BEQ:       next_s = S_EXE_BR;
`ifdef MC_CTRL_BNE_EN
                        OP_BNE:       next_s = S_EXE_BR;
`endif
                        OP_LW, OP_SW: next_s = S_EXE_MA;
                        OP_J:         next_s = S_JMP;
                        default:      begin next_s = S_TRAP; cause_nxt_s = CAUSE_OP; end
                    endcase
                end
                S_EXE_R: begin
                    alu_src_a = 1'b1; alu_src_b = 3'd0; alu_op = ALU_ADD; next_s = S_WB_R;
                    case (func)
                        F_ADD:   alu_op = ALU_ADD;
                        F_SUB:   alu_op = ALU_SUB;
                        F_AND:   alu_op = ALU_AND;
                        F_OR:    alu_op = ALU_OR;
                        F_SLT:   alu_op = ALU_SLT;
                        default: begin next_s = S_TRAP; cause_nxt_s = CAUSE_FUNC; end
                    endcase
                end
                S_EXE_I: begin
                    alu_src_a = 1'b1; alu_src_b = 3'd2; alu_op = ALU_ADD; next_s = S_WB_I;
                end
                S_EXE_MA: begin
                    alu_src_a = 1'b1; alu_src_b = 3'd2; alu_op = ALU_ADD;
                    if (op == OP_LW) next_s = S_MEM_LW;
                    else             next_s = S_MEM_SW;
                end
                S_EXE_BR: begin
                    alu_src_a = 1'b1; alu_src_b = 3'd0; alu_op = ALU_SUB;
                    pc_src = 2'd1; pc_wr_cond = 1'b1; next_s = S_IF;
`ifdef MC_CTRL_BNE_EN
                    br_ne = (op == OP_BNE);
`endif
                end
                S_MEM_LW: begin
                    mem_rd = 1'b1; i_or_d = 1'b1; mdr_wr = mem_ack;
                    if (mem_ack)        next_s = S_WB_LW;
                    else if (timeout_s) begin next_s = S_TRAP; cause_nxt_s = CAUSE_TO; end
                    else                next_s = S_MEM_LW;
                end
                S_MEM_SW: begin
                    mem_wr = 1'b1; i_or_d = 1'b1;
                    if (mem_ack)        next_s = S_IF;
                    else if (timeout_s) begin next_s = S_TRAP; cause_nxt_s = CAUSE_TO; end
                    else                next_s = S_MEM_SW;
                end
                S_WB_R:  begin reg_wr = 1'b1; reg_dst = 1'b1; next_s = S_IF; end
                S_WB_I:  begin reg_wr = 1'b1; next_s = S_IF; end
                S_WB_LW: begin reg_wr = 1'b1; mem_to_reg = 1'b1; next_s = S_IF; end
                S_JMP:   begin pc_src = 2'd2; pc_wr = 1'b1; next_s = S_IF; end
                S_TRAP: begin
                    trap = 1'b1;
                    if (trap_clr) begin next_s = S_IF; cause_nxt_s = CAUSE_NONE; end
                    else          next_s = S_TRAP;
                end
                default: begin
                    state_o = 4'd0; trap_cause = 2'd0; next_s = S_IF;
                end
            endcase
        end
    end

    // Wait counter runs only while staying in a memory-wait state without ack, saturating at all-ones.
    always_comb begin
        wait_nxt_s = {TO_W{1'b0}};
        if ((state_r == S_IF || state_r == S_MEM_LW || state_r == S_MEM_SW) &&
            !mem_ack && next_s == state_r) begin
            if (wait_cnt_r != WAIT_SAT) wait_nxt_s = wait_cnt_r + TO_W'(1'b1);
            else                        wait_nxt_s = wait_cnt_r;
        end else begin
            wait_nxt_s = {TO_W{1'b0}};
        end
    end

endmodule

// File: tb/tb_mc_ctrl_fsm.sv
// Directed bench for mc_ctrl_fsm: one linear stimulus sequence, immediate-assertion checks at each step.
module tb_mc_ctrl_fsm;

    logic       clk = 1'b0;
    logic       nrst;
    logic [5:0] op, func;
    logic       mem_ack, trap_clr;
    logic       ir_wr, mdr_wr, rega_wr, regb_wr, reg_wr, reg_dst, mem_to_reg, alu_src_a;
    logic [2:0] alu_src_b;
    logic [3:0] alu_op;
    logic [1:0] pc_src;
    logic       pc_wr, pc_wr_cond, i_or_d, mem_rd, mem_wr, trap;
    logic [1:0] trap_cause;
    logic [3:0] state_o;
`ifdef MC_CTRL_BNE_EN
    logic       br_ne;
`endif

    int vectors = 0;
    int errors  = 0;

    mc_ctrl_fsm #(.OP_W(6), .FUNC_W(6), .ALUOP_W(4), .TO_W(4), .TO_MAX(15)) dut (
        .clk(clk), .nrst(nrst), .op(op), .func(func), .mem_ack(mem_ack), .trap_clr(trap_clr),
        .ir_wr(ir_wr), .mdr_wr(mdr_wr), .rega_wr(rega_wr), .regb_wr(regb_wr),
        .reg_wr(reg_wr), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg),
        .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op), .pc_src(pc_src),
        .pc_wr(pc_wr), .pc_wr_cond(pc_wr_cond), .i_or_d(i_or_d), .mem_rd(mem_rd), .mem_wr(mem_wr),
        .trap(trap), .trap_cause(trap_cause), .state_o(state_o)
`ifdef MC_CTRL_BNE_EN
        , .br_ne(br_ne)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One cycle: drive inputs at the falling edge, outputs settle 1 time unit later.
    task automatic go(input logic [5:0] o, input logic [5:0] f, input logic a, input logic c);
        @(negedge clk);
        op = o; func = f; mem_ack = a; trap_clr = c;
        #1;
    endtask

    initial begin
        nrst = 1'b0; op = 6'h00; func = 6'h00; mem_ack = 1'b0; trap_clr = 1'b0;
        #2;
        chk("rst_state", 32'(state_o), 0);
        chk("rst_mem_rd", 32'(mem_rd), 0);
        chk("rst_alu_src_b", 32'(alu_src_b), 0);
        chk("rst_trap_cause", 32'(trap_cause), 0);

        @(negedge clk); nrst = 1'b1; #1;
        chk("if_state", 32'(state_o), 0);
        chk("if_mem_rd", 32'(mem_rd), 1);
        chk("if_alu_src_b", 32'(alu_src_b), 1);
        chk("if_alu_op", 32'(alu_op), 2);
        chk("if_ir_wr_noack", 32'(ir_wr), 0);

        // R-type SUB
        go(6'h00, 6'h22, 1'b1, 1'b0);
        chk("r_if_ir_wr", 32'(ir_wr), 1);
        chk("r_if_pc_wr", 32'(pc_wr), 1);
        go(6'h00, 6'h22, 1'b0, 1'b0);
        chk("r_id_state", 32'(state_o), 1);
        chk("r_id_rega", 32'(rega_wr), 1);
        chk("r_id_srcb", 32'(alu_src_b), 3);
        go(6'h00, 6'h22, 1'b0, 1'b0);
        chk("r_exe_state", 32'(state_o), 2);
        chk("r_exe_alu_op", 32'(alu_op), 6);
        chk("r_exe_src_a", 32'(alu_src_a), 1);
        go(6'h00, 6'h22, 1'b0, 1'b0);
        chk("r_wb_state", 32'(state_o), 8);
        chk("r_wb_reg_wr", 32'(reg_wr), 1);
        chk("r_wb_reg_dst", 32'(reg_dst), 1);
        go(6'h00, 6'h22, 1'b0, 1'b0);
        chk("r_back_if", 32'(state_o), 0);

        // ADDI
        go(6'h08, 6'h00, 1'b1, 1'b0);
        go(6'h08, 6'h00, 1'b0, 1'b0);
        go(6'h08, 6'h00, 1'b0, 1'b0);
        chk("addi_exe_state", 32'(state_o), 3);
        chk("addi_exe_srcb", 32'(alu_src_b), 2);
        go(6'h08, 6'h00, 1'b0, 1'b0);
        chk("addi_wb_state", 32'(state_o), 9);
        chk("addi_wb_reg_dst", 32'(reg_dst), 0);
        chk("addi_wb_reg_wr", 32'(reg_wr), 1);

        // LW with three wait cycles in MEM_LW
        go(6'h23, 6'h00, 1'b1, 1'b0);
        chk("lw_c1_if", 32'(state_o), 0);
        go(6'h23, 6'h00, 1'b0, 1'b0);
        chk("lw_c2_id", 32'(state_o), 1);
        go(6'h23, 6'h00, 1'b0, 1'b0);
        chk("lw_c3_ma", 32'(state_o), 5);
        for (int i = 0; i < 3; i++) begin
            go(6'h23, 6'h00, 1'b0, 1'b0);
            chk("lw_wait_state", 32'(state_o), 6);
            chk("lw_wait_mdr_wr", 32'(mdr_wr), 0);
        end
        chk("lw_i_or_d", 32'(i_or_d), 1);
        go(6'h23, 6'h00, 1'b1, 1'b0);
        chk("lw_c7_state", 32'(state_o), 6);
        chk("lw_ack_mdr_wr", 32'(mdr_wr), 1);
        go(6'h23, 6'h00, 1'b0, 1'b0);
        chk("lw_c8_wb", 32'(state_o), 10);
        chk("lw_wb_mem_to_reg", 32'(mem_to_reg), 1);
        chk("lw_wb_mdr_wr", 32'(mdr_wr), 0);
        go(6'h23, 6'h00, 1'b0, 1'b0);
        chk("lw_done_if", 32'(state_o), 0);

        // SW with one wait cycle
        go(6'h2B, 6'h00, 1'b1, 1'b0);
        go(6'h2B, 6'h00, 1'b0, 1'b0);
        go(6'h2B, 6'h00, 1'b0, 1'b0);
        go(6'h2B, 6'h00, 1'b0, 1'b0);
        chk("sw_state", 32'(state_o), 7);
        chk("sw_mem_wr", 32'(mem_wr), 1);
        chk("sw_mem_rd", 32'(mem_rd), 0);
        go(6'h2B, 6'h00, 1'b1, 1'b0);
        chk("sw_ack_state", 32'(state_o), 7);
        go(6'h2B, 6'h00, 1'b0, 1'b0);
        chk("sw_done_if", 32'(state_o), 0);

        // BEQ
        go(6'h04, 6'h00, 1'b1, 1'b0);
        go(6'h04, 6'h00, 1'b0, 1'b0);
        go(6'h04, 6'h00, 1'b0, 1'b0);
        chk("beq_state", 32'(state_o), 4);
        chk("beq_pc_wr_cond", 32'(pc_wr_cond), 1);
        chk("beq_pc_src", 32'(pc_src), 1);
        chk("beq_alu_op", 32'(alu_op), 6);
        go(6'h04, 6'h00, 1'b0, 1'b0);
        chk("beq_done_if", 32'(state_o), 0);

        // J
        go(6'h02, 6'h00, 1'b1, 1'b0);
        go(6'h02, 6'h00, 1'b0, 1'b0);
        go(6'h02, 6'h00, 1'b0, 1'b0);
        chk("j_state", 32'(state_o), 11);
        chk("j_pc_src", 32'(pc_src), 2);
        chk("j_pc_wr", 32'(pc_wr), 1);

        // Illegal opcode
        go(6'h3F, 6'h00, 1'b1, 1'b0);
        chk("ill_if", 32'(state_o), 0);
        go(6'h3F, 6'h00, 1'b0, 1'b0);
        chk("ill_id", 32'(state_o), 1);
        go(6'h3F, 6'h00, 1'b0, 1'b0);
        chk("ill_trap_state", 32'(state_o), 12);
        chk("ill_trap", 32'(trap), 1);
        chk("ill_cause", 32'(trap_cause), 1);
        chk("ill_mem_rd", 32'(mem_rd), 0);
        go(6'h3F, 6'h00, 1'b1, 1'b0);
        chk("ill_sticky", 32'(state_o), 12);
        go(6'h3F, 6'h00, 1'b0, 1'b1);
        chk("ill_clr_cycle", 32'(trap_cause), 1);
        go(6'h00, 6'h00, 1'b1, 1'b0);
        chk("ill_after_clr_state", 32'(state_o), 0);
        chk("ill_after_clr_cause", 32'(trap_cause), 0);
        chk("ill_after_clr_mem_rd", 32'(mem_rd), 1);

        // Illegal funct (fetch acked above)
        go(6'h00, 6'h3F, 1'b0, 1'b0);
        go(6'h00, 6'h3F, 1'b0, 1'b0);
        chk("func_exe", 32'(state_o), 2);
        go(6'h00, 6'h3F, 1'b0, 1'b0);
        chk("func_trap", 32'(state_o), 12);
        chk("func_cause", 32'(trap_cause), 2);
        go(6'h00, 6'h3F, 1'b0, 1'b1);

        // Opcode 0x05
        go(6'h05, 6'h00, 1'b1, 1'b0);
        go(6'h05, 6'h00, 1'b0, 1'b0);
        chk("bne_id", 32'(state_o), 1);
        go(6'h05, 6'h00, 1'b0, 1'b0);
`ifdef MC_CTRL_BNE_EN
        chk("bne_state", 32'(state_o), 4);
        chk("bne_br_ne", 32'(br_ne), 1);
`else
        chk("bne_trap", 32'(state_o), 12);
        chk("bne_cause", 32'(trap_cause), 1);
        go(6'h00, 6'h20, 1'b0, 1'b1);
`endif

        // Fetch timeout: 16 IF cycles without ack, then TRAP cause 3
        for (int i = 0; i < 16; i++) begin
            go(6'h00, 6'h20, 1'b0, 1'b0);
            chk("to_if_hold", 32'(state_o), 0);
        end
        go(6'h00, 6'h20, 1'b0, 1'b0);
        chk("to_trap_state", 32'(state_o), 12);
        chk("to_cause", 32'(trap_cause), 3);
        go(6'h00, 6'h20, 1'b0, 1'b1);

        // Ack on the 16th IF cycle wins over timeout
        for (int i = 0; i < 15; i++) begin
            go(6'h23, 6'h00, 1'b0, 1'b0);
        end
        chk("to_late_still_if", 32'(state_o), 0);
        go(6'h23, 6'h00, 1'b1, 1'b0);
        chk("to_late_ack_state", 32'(state_o), 0);
        go(6'h23, 6'h00, 1'b0, 1'b0);
        chk("to_late_id", 32'(state_o), 1);
        chk("to_late_cause", 32'(trap_cause), 0);

        // Reset in the middle of MEM_LW
        go(6'h23, 6'h00, 1'b0, 1'b0);
        go(6'h23, 6'h00, 1'b0, 1'b0);
        chk("mrst_pre_state", 32'(state_o), 6);
        chk("mrst_pre_mem_rd", 32'(mem_rd), 1);
        nrst = 1'b0;
        #1;
        chk("mrst_mem_rd", 32'(mem_rd), 0);
        chk("mrst_i_or_d", 32'(i_or_d), 0);
        chk("mrst_state", 32'(state_o), 0);
        @(negedge clk); nrst = 1'b1; mem_ack = 1'b0; #1;
        chk("mrst_rel_state", 32'(state_o), 0);
        chk("mrst_rel_mem_rd", 32'(mem_rd), 1);
        chk("mrst_rel_i_or_d", 32'(i_or_d), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
